if_fetch_unit: RTL and testbench

F-stage fetch engine that sits on the receiving end of the next-PC interface. It owns the fetch PC register and issues word requests to a synchronous instruction memory with 1-cycle read latency. Returned instructions go into a small buffer, and the buffer hands {pc, instr} to the D stage with a valid/ready handshake. D-stage branch/jump redirects come with MIPS delay-slot semantics: the delay-slot instruction is always preserved, and everything younger is discarded.

---
 rtl/if_fetch_unit_pkg.sv | 20 ++
 rtl/if_fetch_unit_buf.sv | 64 ++++++
 rtl/if_fetch_unit.sv | 95 +++++++++
 tb/tb_if_fetch_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the F-stage fetch unit.
package if_fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam int          DEF_BUF_DEPTH = 2;

  // One fetched word, tagged with the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // A count field must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_w(DEF_BUF_DEPTH);

endpackage

// File: rtl/if_fetch_unit_buf.sv
// Circular fetch buffer with head-preserving and full flush.
module fetch_buf
  import if_fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = cnt_w(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush_all,
  input  logic          flush_younger,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, wr_idx;

  assign head = mem[rd_ptr];

  // A head-preserving flush truncates the queue right behind the head,
  // so any push accepted that cycle lands in the slot after the head.
  always_comb begin
    wr_idx = wr_ptr;
    if (flush_younger && !flush_all) wr_idx = rd_ptr + PW'(1);
  end

  // Entry storage; no reset needed because head is qualified by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= push_entry;
  end

  // Pointer and occupancy bookkeeping, flushes taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_all) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= wr_ptr + PW'(push);
      count  <= CW'(push);
    end else if (flush_younger) begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_idx + PW'(push);
      count  <= CW'(!pop) + CW'(push);
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  // Issue throttling guarantees room for every response.
  always_ff @(posedge clk) begin
    if (!reset && !flush_all && !flush_younger)
      assert (!(push && !pop && count == CW'(DEPTH)));
  end

endmodule

// File: rtl/if_fetch_unit.sv
// F-stage fetch engine: owns the fetch PC, issues IM reads, buffers
// returned words and applies D-stage redirects with delay-slot semantics.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          BUF_DEPTH = DEF_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic        D_valid,
  input  logic        D_ready,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] ds_pc
);

  localparam int CW = cnt_w(BUF_DEPTH);
  localparam int OW = CW + 1;

  logic [31:0]   fpc, ipc, ptgt, tgt;
  logic          inf, pend;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic [OW-1:0] occ;
  logic          head_valid, pop, issue, push, kill;
  logic          hit_head, hit_inf, flush_all, flush_younger;

  assign head_valid = (count != '0) && !reset;
  assign D_valid    = head_valid;
  assign D_pc       = head_valid ? head.pc    : '0;
  assign D_instr    = head_valid ? head.instr : '0;
  assign pop        = D_valid & D_ready;

  // Slots already claimed once this cycle's pop leaves: buffered + in flight.
  assign occ     = {1'b0, count} + OW'(inf) - OW'(pop);
  assign issue   = !reset && !redirect && (occ < OW'(BUF_DEPTH));
  assign im_req  = issue;
  assign im_addr = fpc;

  // Redirect decode: find where the delay slot lives right now.
  assign tgt           = redirect_pc & ~32'h3;
  assign hit_head      = redirect && head_valid && (head.pc == ds_pc);
  assign hit_inf       = redirect && !hit_head && inf && (ipc == ds_pc);
  assign flush_younger = hit_head;
  assign flush_all     = redirect && !hit_head;
  assign kill          = redirect && !hit_inf;
  assign push          = inf && !kill && !reset;

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .push_entry    ('{pc: ipc, instr: im_rdata}),
    .pop           (pop),
    .flush_all     (flush_all),
    .flush_younger (flush_younger),
    .head          (head),
    .count         (count)
  );

  // Fetch PC, in-flight tag and deferred-target state.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc  <= RESET_PC;
      inf  <= 1'b0;
      ipc  <= '0;
      pend <= 1'b0;
      ptgt <= '0;
    end else begin
      inf <= issue;
      if (issue) ipc <= fpc;
      if (redirect) begin
        if (hit_head || hit_inf) begin
          fpc  <= tgt;
          pend <= 1'b0;
        end else begin
          // Delay slot not fetched yet: fetch it first, then jump.
          fpc  <= ds_pc;
          pend <= 1'b1;
          ptgt <= tgt;
        end
      end else if (issue) begin
        fpc  <= pend ? ptgt : fpc + 32'd4;
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: expected {pc,instr} deliveries are
// queued per scenario and matched against every D-stage handshake.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, D_ready, redirect;
  logic [31:0] redirect_pc, ds_pc, im_rdata;
  logic        im_req, D_valid;
  logic [31:0] im_addr, D_pc, D_instr;

  int checks = 0;
  int errors = 0;
  fetch_entry_t exp_q[$];

  logic        s_req, s_valid, s_fired;
  logic [31:0] s_addr, s_pc, s_instr;

  if_fetch_unit #(.RESET_PC(32'h0000_3000), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .im_req(im_req), .im_addr(im_addr),
    .im_rdata(im_rdata), .D_valid(D_valid), .D_ready(D_ready),
    .D_pc(D_pc), .D_instr(D_instr), .redirect(redirect),
    .redirect_pc(redirect_pc), .ds_pc(ds_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address A reads back as A+1, one cycle later.
  always @(posedge clk) im_rdata <= im_req ? im_addr + 32'd1 : 32'hDEAD_BEEF;

  // Inputs are driven at the negedge; sample 1 time unit later, then advance.
  task automatic tick();
    #1;
    s_req   = im_req;
    s_addr  = im_addr;
    s_valid = D_valid;
    s_pc    = D_pc;
    s_instr = D_instr;
    s_fired = D_valid & D_ready;
    @(negedge clk);
  endtask

  task automatic exp_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{pc: start + 32'(4 * i), instr: start + 32'(4 * i) + 32'd1});
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; D_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; D_ready = 1'b1; redirect = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (s_valid !== 1'b0 || s_req !== 1'b0 || s_pc !== 32'h0 || s_instr !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b req=%b pc=%h instr=%h, want 0 0 0 0",
                 s_valid, s_req, s_pc, s_instr);
      end
    end
    reset = 1'b0;
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h3000 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got req=%b addr=%h valid=%b, want 1 00003000 0",
               s_req, s_addr, s_valid);
    end
  endtask

  task automatic test_stream();
    fetch_entry_t e;
    do_reset(); D_ready = 1'b1;
    exp_seq(32'h3000, 6);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      tick();
      if (c < 2) begin
        checks++;
        if (s_valid !== 1'b0 || s_addr !== 32'h3000 + 32'(4 * c)) begin
          errors++;
          $display("FAIL stream_lat c%0d: got valid=%b addr=%h, want 0 %h",
                   c, s_valid, s_addr, 32'h3000 + 32'(4 * c));
        end
      end else begin
        checks++;
        if (s_fired !== 1'b1) begin
          errors++;
          $display("FAIL stream_thru c%0d: got fired=%b, want 1", c, s_fired);
        end
      end
      if (s_fired && exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (s_pc !== e.pc || s_instr !== e.instr) begin
          errors++;
          $display("FAIL stream_deliv: got %h/%h, want %h/%h", s_pc, s_instr, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_drain: got %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    fetch_entry_t e;
    do_reset(); D_ready = 1'b0;
    exp_seq(32'h3000, 6);
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c >= 2) begin
        checks++;
        if (s_req !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall_req c%0d: got req=%b, want 0", c, s_req);
        end
      end
    end
    checks++;
    if (s_valid !== 1'b1 || s_pc !== 32'h3000) begin
      errors++;
      $display("FAIL bp_head: got valid=%b pc=%h, want 1 00003000", s_valid, s_pc);
    end
    D_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      tick();
      if (s_fired && exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (s_pc !== e.pc || s_instr !== e.instr) begin
          errors++;
          $display("FAIL bp_deliv: got %h/%h, want %h/%h", s_pc, s_instr, e.pc, e.instr);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got %0d left, want 0", exp_q.size());
    end
  endtask

  // Delay slot sitting at the buffer head; hold=1 fills the buffer first.
  task automatic test_redirect_head(input bit hold);
    fetch_entry_t e;
    int rc;
    rc = hold ? 5 : 4;
    do_reset();
    ds_pc = 32'h3008; redirect_pc = 32'h3403;
    exp_seq(32'h3000, 3); exp_seq(32'h3400, 2);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      D_ready  = hold ? !(c == 4 || c == 5) : 1'b1;
      redirect = (c == rc);
      tick();
      if (c == rc) begin
        checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'h3008 || s_req !== 1'b0) begin
          errors++;
          $display("FAIL rdh_setup h%0d: got valid=%b pc=%h req=%b, want 1 00003008 0",
                   hold, s_valid, s_pc, s_req);
        end
      end
      if (c == rc + 1) begin
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h3400) begin
          errors++;
          $display("FAIL rdh_target h%0d: got req=%b addr=%h, want 1 00003400", hold, s_req, s_addr);
        end
      end
      if (s_fired && exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (s_pc !== e.pc || s_instr !== e.instr) begin
          errors++;
          $display("FAIL rdh_deliv h%0d: got %h/%h, want %h/%h", hold, s_pc, s_instr, e.pc, e.instr);
        end
      end
    end
    redirect = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rdh_drain h%0d: got %0d left, want 0", hold, exp_q.size());
    end
  endtask

  // Delay slot is the in-flight word; v=0 truly empty buffer, v=1 head popping.
  task automatic test_redirect_inflight(input bit v);
    fetch_entry_t e;
    int rc;
    rc = v ? 3 : 1;
    do_reset(); D_ready = 1'b1;
    ds_pc = v ? 32'h3008 : 32'h3000; redirect_pc = 32'h3400;
    exp_seq(32'h3000, v ? 3 : 1); exp_seq(32'h3400, 2);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      redirect = (c == rc);
      tick();
      if (c == rc) begin
        checks++;
        if (s_req !== 1'b0) begin
          errors++;
          $display("FAIL rdi_req v%0d: got req=%b, want 0", v, s_req);
        end
      end
      if (c == rc + 1) begin
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h3400) begin
          errors++;
          $display("FAIL rdi_target v%0d: got req=%b addr=%h, want 1 00003400", v, s_req, s_addr);
        end
      end
      if (s_fired && exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (s_pc !== e.pc || s_instr !== e.instr) begin
          errors++;
          $display("FAIL rdi_deliv v%0d: got %h/%h, want %h/%h", v, s_pc, s_instr, e.pc, e.instr);
        end
      end
    end
    redirect = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rdi_drain v%0d: got %0d left, want 0", v, exp_q.size());
    end
  endtask

  // Delay slot not fetched; v=1 re-redirects while the target is pending.
  task automatic test_redirect_unfetched(input bit v);
    fetch_entry_t e;
    int fc;
    logic [31:0] ds_last, tgt_last;
    fc       = v ? 2 : 1;
    ds_last  = v ? 32'h3010 : 32'h3008;
    tgt_last = v ? 32'h3500 : 32'h3400;
    do_reset(); D_ready = 1'b1;
    exp_seq(ds_last, 1); exp_seq(tgt_last, 2);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      redirect    = (c == 0) || (v && c == 1);
      ds_pc       = (c == 0) ? 32'h3008 : 32'h3010;
      redirect_pc = (c == 0) ? 32'h3400 : 32'h3501;
      tick();
      if (c < fc) begin
        checks++;
        if (s_req !== 1'b0) begin
          errors++;
          $display("FAIL rdu_req v%0d c%0d: got req=%b, want 0", v, c, s_req);
        end
      end
      if (c == fc || c == fc + 1) begin
        checks++;
        if (s_req !== 1'b1 || s_addr !== ((c == fc) ? ds_last : tgt_last)) begin
          errors++;
          $display("FAIL rdu_addr v%0d c%0d: got req=%b addr=%h, want 1 %h",
                   v, c, s_req, s_addr, (c == fc) ? ds_last : tgt_last);
        end
      end
      if (s_fired && exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (s_pc !== e.pc || s_instr !== e.instr) begin
          errors++;
          $display("FAIL rdu_deliv v%0d: got %h/%h, want %h/%h", v, s_pc, s_instr, e.pc, e.instr);
        end
      end
    end
    redirect = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rdu_drain v%0d: got %0d left, want 0", v, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    fetch_entry_t e;
    do_reset(); D_ready = 1'b1;
    exp_seq(32'h3000, 1); exp_seq(32'h3000, 3);
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      reset = (c == 3);
      tick();
      if (c == 3) begin
        checks++;
        if (s_valid !== 1'b0 || s_req !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid_during: got valid=%b req=%b, want 0 0", s_valid, s_req);
        end
      end
      if (c == 4 || c == 5) begin
        checks++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h3000 + 32'(4 * (c - 4))) begin
          errors++;
          $display("FAIL rst_mid_after c%0d: got valid=%b req=%b addr=%h, want 0 1 %h",
                   c, s_valid, s_req, s_addr, 32'h3000 + 32'(4 * (c - 4)));
        end
      end
      if (s_fired && exp_q.size() > 0) begin
        e = exp_q.pop_front(); checks++;
        if (s_pc !== e.pc || s_instr !== e.instr) begin
          errors++;
          $display("FAIL rst_mid_deliv: got %h/%h, want %h/%h", s_pc, s_instr, e.pc, e.instr);
        end
      end
    end
    reset = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_drain: got %0d left, want 0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; D_ready = 1'b0; redirect = 1'b0;
    redirect_pc = '0; ds_pc = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_head(1'b0);
    test_redirect_head(1'b1);
    test_redirect_inflight(1'b0);
    test_redirect_inflight(1'b1);
    test_redirect_unfetched(1'b0);
    test_redirect_unfetched(1'b1);
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
